write_dq_output_drive: RTL and testbench
========================================

// Module: write_dq_output_drive
// PURPOSE
//  Transmit-side DQ/DQS path for the memory transfer interface; counterpart to the read DQ capture path.
//  Buffers 16-bit write words from the controller and emits one word per mem_clk as a rise/fall byte pair.
//  Drives the DQ and DQS output-enables with preamble/postamble framing.
//  Feeds external ODDR cells, which are outside this block; all logic is on mem_clk.
// PARAMETERS
//  FIFO_ADDR_WIDTH  4   log2 of write-buffer depth (16 words)
//  FIFO_DATA_WIDTH  16  buffered word width; byte pair {rise,fall}
//  LEN_WIDTH        12  width of xfer_len, counted in 16-bit words
//  PRE_CYCLES       1   DQS preamble cycles (1..7): DQS driven low, DQ tristated
//  POST_CYCLES      1   DQS postamble cycles (1..7): DQS driven low, DQ tristated
//  START_THRESH     2   words buffered (or all of xfer_len, if smaller) before preamble starts
// PORTS
//  mem_clk                 in   1                  sole clock
//  rst                     in   1                  synchronous, active-high reset
//  flush                   in   1                  abort transfer and empty buffer
//  xfer_start              in   1                  start a write burst; sampled only in IDLE
//  xfer_len                in   LEN_WIDTH          burst length in words; latched on xfer_start
//  din                     in   16                 write word; [15:8]=rise byte, [7:0]=fall byte
//  din_valid               in   1                  din push request
//  din_ready               out  1                  buffer not full
//  wr_dq_fifo_data_avail   out  FIFO_ADDR_WIDTH+1  words currently buffered
//  dq_out_rise             out  8                  byte driven on DQS rising edge
//  dq_out_fall             out  8                  byte driven on DQS falling edge
//  dq_oe                   out  1                  DQ output enable
//  dqs_oe                  out  1                  DQS output enable
//  dqs_en                  out  1                  1 = DQS toggles this cycle; 0 = DQS held low
//  xfer_busy               out  1                  state != IDLE
//  xfer_done               out  1                  one-cycle pulse when a burst completes
//  underrun                out  1                  sticky: buffer emptied mid-DATA; cleared by rst/flush/xfer_start
// BEHAVIOUR
//  Reset / flush values:
//   - All outputs 0, except din_ready=1; FIFO pointers 0; state IDLE.
//   - flush has priority over xfer_start, push and pop in the same cycle; no xfer_done on flush.
//  All outputs registered. A word popped in cycle N appears on dq_out_* in cycle N+1.
//  Buffer:
//   - Push when din_valid & din_ready.
//   - din_ready = ~full. A push at full is dropped, even if a pop occurs the same cycle.
//   - Pointers are FIFO_ADDR_WIDTH+1 bits, with an MSB wrap bit.
//   - Simultaneous push and pop leave data_avail unchanged.
//  FSM:
//   - IDLE -> WAIT on xfer_start with xfer_len != 0; remaining = xfer_len; underrun cleared.
//   - IDLE with xfer_start and xfer_len == 0: stay in IDLE; xfer_done pulses next cycle.
//   - WAIT -> PRE when data_avail >= min(remaining, START_THRESH).
//   - PRE: dqs_oe=1, dqs_en=0, dq_oe=0 for PRE_CYCLES; then -> DATA.
//   - DATA, buffer non-empty: pop; dq_oe=1, dqs_oe=1, dqs_en=1; remaining -= 1.
//   - DATA, buffer empty: stall with dqs_en=0 and dq_out held; set underrun; remaining unchanged.
//   - DATA -> POST on the cycle the last word is popped; that word is driven in the first POST cycle.
//   - POST: dqs_oe=1, dqs_en=0, dq_oe=0 for POST_CYCLES; then -> IDLE with xfer_done pulse.
//  Outside DATA: dq_out_* hold their last value.
//  xfer_start outside IDLE is ignored.
//  Pushes stay legal in every state, so the next burst can prefill.
// STRUCTURE
//  Shared include mem_xfer_defines.vh holds:
//   - FSM state encodings (IDLE/WAIT/PRE/DATA/POST);
//   - RISE/FALL byte-lane slice macros, shared with the read capture path.
//  One sub-module, wr_dq_fifo: single-clock FIFO carrying push/pop, full/empty and data_avail.
//  The top holds the FSM, the remaining-word counter, the pre/post counter and the output registers.
// TESTING
//  1. Push 4 words 0xA1B2,0xC3D4,0xE5F6,0x0718, then xfer_start len=4:
//     -> 1 PRE cycle; 4 DATA cycles with rise/fall = A1/B2, C3/D4, E5/F6, 07/18;
//     -> 1 POST cycle; xfer_done once; underrun=0.
//  2. Push 17 words back-to-back with no xfer:
//     -> din_ready=0 after 16 words; data_avail=16; 17th word dropped.
//  3. len=3, push 1 word, wait 5 cycles, push 2 more:
//     -> stays in WAIT until data_avail>=2; no underrun.
//  4. len=4, prefill 2 words, then 1 push every 3 cycles:
//     -> stall cycles show dqs_en=0; underrun=1; exactly 4 dqs_en=1 cycles in total.
//  5. flush asserted in DATA, after the 2nd word, together with din_valid:
//     -> next cycle IDLE; all oe=0; data_avail=0; no xfer_done.
//  6. xfer_start len=0, and rst asserted mid-PRE:
//     -> len=0 gives one xfer_done with no oe activity;
//     -> rst returns reset values on the next clock.

Source files
------------

// File: rtl/write_dq_output_drive_pkg.sv
// Shared types and byte-lane helpers for the write DQ/DQS output path.
package write_dq_output_drive_pkg;

  // Transfer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StPre,
    StData,
    StPost
  } xfer_state_e;

  // Rise byte of a buffered word. The read capture path uses the same lane split.
  function automatic logic [7:0] rise_byte(input logic [15:0] word);
    return word[15:8];
  endfunction

  // Fall byte of a buffered word.
  function automatic logic [7:0] fall_byte(input logic [15:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/write_dq_output_drive_fifo.sv
// Single-clock write-word buffer with wrap-bit pointers and a fill-level count.
module wr_dq_fifo #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   data_avail
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Full when the index bits match but the wrap bits differ.
  assign full       = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign data_avail = wr_ptr - rd_ptr;
  assign dout       = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // A push at full is dropped even when a pop happens in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer update; flush empties the buffer and beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/write_dq_output_drive.sv
// Write DQ/DQS output drive: buffers write words and frames them with DQS pre/postamble.
module write_dq_output_drive
  import write_dq_output_drive_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH       = 12,
  parameter int unsigned PRE_CYCLES      = 1,
  parameter int unsigned POST_CYCLES     = 1,
  parameter int unsigned START_THRESH    = 2
) (
  input  logic                       mem_clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       xfer_start,
  input  logic [LEN_WIDTH-1:0]       xfer_len,
  input  logic [15:0]                din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [FIFO_ADDR_WIDTH:0]   wr_dq_fifo_data_avail,
  output logic [7:0]                 dq_out_rise,
  output logic [7:0]                 dq_out_fall,
  output logic                       dq_oe,
  output logic                       dqs_oe,
  output logic                       dqs_en,
  output logic                       xfer_busy,
  output logic                       xfer_done,
  output logic                       underrun
);

  localparam logic [LEN_WIDTH-1:0] StartThresh = LEN_WIDTH'(START_THRESH);
  localparam logic [2:0]           PreLast     = 3'(PRE_CYCLES - 1);
  localparam logic [2:0]           PostLast    = 3'(POST_CYCLES - 1);

  xfer_state_e                state;
  logic [LEN_WIDTH-1:0]       remaining;
  logic [2:0]                 frame_cnt;
  logic [FIFO_DATA_WIDTH-1:0] fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic [LEN_WIDTH-1:0]       start_need;
  logic                       start_ok;

  assign pop       = (state == StData) && !fifo_empty;
  assign din_ready = !fifo_full;
  assign xfer_busy = (state != StIdle);

  // Short bursts start as soon as the whole burst is buffered.
  assign start_need = (remaining < StartThresh) ? remaining : StartThresh;
  assign start_ok   = LEN_WIDTH'(wr_dq_fifo_data_avail) >= start_need;

  wr_dq_fifo #(
    .ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .DATA_WIDTH (FIFO_DATA_WIDTH)
  ) u_fifo (
    .clk        (mem_clk),
    .rst        (rst),
    .flush      (flush),
    .push       (din_valid),
    .din        (din),
    .pop        (pop),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .data_avail (wr_dq_fifo_data_avail)
  );

  // Transfer FSM with registered DQ/DQS drive; outputs show the frame chosen last cycle.
  always_ff @(posedge mem_clk) begin
    if (rst || flush) begin
      state       <= StIdle;
      remaining   <= '0;
      frame_cnt   <= '0;
      dq_out_rise <= '0;
      dq_out_fall <= '0;
      dq_oe       <= 1'b0;
      dqs_oe      <= 1'b0;
      dqs_en      <= 1'b0;
      xfer_done   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      unique case (state)
        StIdle: begin
          dq_oe  <= 1'b0;
          dqs_oe <= 1'b0;
          dqs_en <= 1'b0;
          if (xfer_start) begin
            underrun <= 1'b0;
            if (xfer_len != '0) begin
              state     <= StWait;
              remaining <= xfer_len;
            end else begin
              xfer_done <= 1'b1;
            end
          end
        end
        StWait: begin
          dq_oe  <= 1'b0;
          dqs_oe <= 1'b0;
          dqs_en <= 1'b0;
          if (start_ok) begin
            state     <= StPre;
            frame_cnt <= '0;
          end
        end
        StPre: begin
          dq_oe  <= 1'b0;
          dqs_oe <= 1'b1;
          dqs_en <= 1'b0;
          if (frame_cnt == PreLast) state <= StData;
          else                      frame_cnt <= frame_cnt + 1'b1;
        end
        StData: begin
          dq_oe  <= 1'b1;
          dqs_oe <= 1'b1;
          if (!fifo_empty) begin
            dq_out_rise <= rise_byte(fifo_dout);
            dq_out_fall <= fall_byte(fifo_dout);
            dqs_en      <= 1'b1;
            remaining   <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state     <= StPost;
              frame_cnt <= '0;
            end
          end else begin
            // Starved: hold DQS low and the last byte pair until data arrives.
            dqs_en   <= 1'b0;
            underrun <= 1'b1;
          end
        end
        StPost: begin
          dq_oe  <= 1'b0;
          dqs_oe <= 1'b1;
          dqs_en <= 1'b0;
          if (frame_cnt == PostLast) begin
            state     <= StIdle;
            xfer_done <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_write_dq_output_drive.sv
// Scoreboard bench for the write DQ/DQS output drive.
module tb_write_dq_output_drive;

  logic        mem_clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        xfer_start;
  logic [11:0] xfer_len;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [4:0]  wr_dq_fifo_data_avail;
  logic [7:0]  dq_out_rise;
  logic [7:0]  dq_out_fall;
  logic        dq_oe;
  logic        dqs_oe;
  logic        dqs_en;
  logic        xfer_busy;
  logic        xfer_done;
  logic        underrun;

  write_dq_output_drive dut (
    .mem_clk               (mem_clk),
    .rst                   (rst),
    .flush                 (flush),
    .xfer_start            (xfer_start),
    .xfer_len              (xfer_len),
    .din                   (din),
    .din_valid             (din_valid),
    .din_ready             (din_ready),
    .wr_dq_fifo_data_avail (wr_dq_fifo_data_avail),
    .dq_out_rise           (dq_out_rise),
    .dq_out_fall           (dq_out_fall),
    .dq_oe                 (dq_oe),
    .dqs_oe                (dqs_oe),
    .dqs_en                (dqs_en),
    .xfer_busy             (xfer_busy),
    .xfer_done             (xfer_done),
    .underrun              (underrun)
  );

  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int en_cnt = 0;
  int done_cnt = 0;
  int frame_cnt = 0;
  int stall_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every DQS-toggling cycle must carry the next scoreboard word.
  always @(negedge mem_clk) begin
    if (dqs_en === 1'b1) begin
      en_cnt++;
      check("oe_in_data", {30'd0, dq_oe, dqs_oe}, 32'd3);
      check("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("dq_word", {16'd0, dq_out_rise, dq_out_fall},
                                  {16'd0, exp_q.pop_front()});
    end
    if (dqs_oe === 1'b1 && dq_oe === 1'b0) frame_cnt++;
    if (dqs_oe === 1'b1 && dq_oe === 1'b1 && dqs_en === 1'b0) stall_cnt++;
    if (xfer_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w, input bit accept);
    din       = w;
    din_valid = 1'b1;
    if (accept) exp_q.push_back(w);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic start(input logic [11:0] len);
    xfer_start = 1'b1;
    xfer_len   = len;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int base;
    base = done_cnt;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done_cnt > base) break;
    end
    tick();
    check("xfer_done_count", done_cnt - base, 1);
  endtask

  int en_b, fr_b, st_b, dn_b;

  initial begin
    rst = 1'b1; flush = 1'b0; xfer_start = 1'b0; xfer_len = '0; din = '0; din_valid = 1'b0;
    repeat (2) tick();
    check("rst_din_ready", {31'd0, din_ready}, 1);
    check("rst_outputs", {dq_out_rise, dq_out_fall, 5'd0, dq_oe, dqs_oe, dqs_en},
          32'd0);
    check("rst_status", {27'd0, wr_dq_fifo_data_avail}, 0);
    check("rst_flags", {29'd0, xfer_busy, xfer_done, underrun}, 0);
    rst = 1'b0;
    tick();

    // 1: four-word burst with full framing.
    push_word(16'hA1B2, 1); push_word(16'hC3D4, 1);
    push_word(16'hE5F6, 1); push_word(16'h0718, 1);
    en_b = en_cnt; fr_b = frame_cnt;
    start(12'd4);
    wait_done(40);
    check("t1_en_cycles", en_cnt - en_b, 4);
    check("t1_pre_post_frames", frame_cnt - fr_b, 2);
    check("t1_underrun", {31'd0, underrun}, 0);
    check("t1_queue_drained", exp_q.size(), 0);
    check("t1_idle_oe", {30'd0, dq_oe, dqs_oe}, 0);

    // 2: overfill the buffer with no transfer running.
    for (int i = 0; i < 17; i++) begin
      check("t2_din_ready", {31'd0, din_ready}, (i < 16) ? 1 : 0);
      push_word(16'h1000 + 16'(i), i < 16);
    end
    check("t2_avail_full", {27'd0, wr_dq_fifo_data_avail}, 16);
    check("t2_ready_low", {31'd0, din_ready}, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("t2_flush_avail", {27'd0, wr_dq_fifo_data_avail}, 0);
    check("t2_flush_ready", {31'd0, din_ready}, 1);

    // 3: burst waits in WAIT until the start threshold is met.
    en_b = en_cnt;
    start(12'd3);
    push_word(16'h1122, 1);
    repeat (5) tick();
    check("t3_wait_busy", {31'd0, xfer_busy}, 1);
    check("t3_wait_no_drive", {30'd0, dqs_oe, dq_oe}, 0);
    push_word(16'h3344, 1);
    push_word(16'h5566, 1);
    wait_done(40);
    check("t3_en_cycles", en_cnt - en_b, 3);
    check("t3_underrun", {31'd0, underrun}, 0);

    // 4: slow feeder starves DATA.
    en_b = en_cnt; st_b = stall_cnt;
    push_word(16'h8899, 1); push_word(16'hAABB, 1);
    start(12'd4);
    for (int k = 0; k < 2; k++) begin
      repeat (2) tick();
      push_word(16'hCC00 + 16'(k), 1);
    end
    wait_done(60);
    check("t4_en_cycles", en_cnt - en_b, 4);
    check("t4_underrun", {31'd0, underrun}, 1);
    check("t4_stall_seen", {31'd0, (stall_cnt - st_b) > 0}, 1);

    // 5: flush during DATA together with a push.
    push_word(16'h0102, 1); push_word(16'h0304, 1);
    push_word(16'h0506, 1); push_word(16'h0708, 1);
    en_b = en_cnt; dn_b = done_cnt;
    start(12'd4);
    for (int i = 0; i < 30; i++) begin
      if (en_cnt - en_b >= 2) break;
      tick();
    end
    check("t5_reached_data", {31'd0, (en_cnt - en_b) >= 2}, 1);
    flush = 1'b1; din = 16'hDEAD; din_valid = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    exp_q.delete();
    check("t5_idle", {31'd0, xfer_busy}, 0);
    check("t5_oe", {29'd0, dq_oe, dqs_oe, dqs_en}, 0);
    check("t5_avail", {27'd0, wr_dq_fifo_data_avail}, 0);
    repeat (3) tick();
    check("t5_no_done", done_cnt - dn_b, 0);

    // 6a: zero-length start completes immediately.
    start(12'd0);
    check("t6_len0_done", {31'd0, xfer_done}, 1);
    check("t6_len0_busy", {30'd0, xfer_busy, dqs_oe}, 0);
    tick();
    check("t6_len0_pulse", {30'd0, xfer_done, dq_oe}, 0);

    // 6b: reset in the middle of the preamble.
    push_word(16'h4242, 1); push_word(16'h4343, 1);
    xfer_start = 1'b1; xfer_len = 12'd2;
    tick();
    xfer_start = 1'b0;
    tick();
    check("t6_pre_busy", {31'd0, xfer_busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_rst_flags", {29'd0, xfer_busy, xfer_done, underrun}, 0);
    check("t6_rst_oe", {29'd0, dq_oe, dqs_oe, dqs_en}, 0);
    check("t6_rst_fifo", {26'd0, din_ready, wr_dq_fifo_data_avail}, 32'h20);
    check("t6_rst_dq", {16'd0, dq_out_rise, dq_out_fall}, 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
